// File: rtl/status_feeder.sv
// Event-to-status-latch feeder: queues exception/setx events and drains them one per cycle.
// Define STATUS_FEEDER_DROP_CNT_EN to build the saturating lost-event counter.
module status_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        evt_valid,
  input  logic [2:0]  evt_code,
  input  logic        setx_valid,
  input  logic [26:0] setx_imm,
  input  logic        hold,
  output logic [31:0] status_data,
  output logic        status_w_en,
  output logic        full,
  output logic        empty,
  output logic        dropped,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic        evt_ok;
  logic        push;
  logic        pop;
  logic        room;
  logic        do_push;
  logic        collide;
  logic        overflow;
  logic [1:0]  lost;
  logic [31:0] push_data;

  assign evt_ok    = evt_valid && (evt_code inside {[3'd1:3'd5]});
  assign push      = evt_ok || setx_valid;
  assign push_data = evt_ok ? {29'b0, evt_code}
                            : {5'b0, setx_imm};

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign pop      = !empty && !hold;
  assign room     = !full || pop;
  assign do_push  = push && room;
  assign collide  = evt_ok && setx_valid;
  assign overflow = push && !room;
  assign lost     = {1'b0, collide} + {1'b0, overflow};

  always_ff @(posedge clk) begin
    if (!clr && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      status_data <= '0;
      status_w_en <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      status_w_en <= pop;
      if (pop) begin
        status_data <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (lost != 2'd0) begin
        dropped <= 1'b1;
      end
    end
  end

`ifdef STATUS_FEEDER_DROP_CNT_EN
  logic [7:0] cnt_q;
  logic [8:0] cnt_sum;

  assign cnt_sum = {1'b0, cnt_q} + {7'b0, lost};

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (cnt_sum[8]) begin
      cnt_q <= 8'hFF;
    end else begin
      cnt_q <= cnt_sum[7:0];
    end
  end

  assign drop_cnt = cnt_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_status_feeder.sv
// Bench for status_feeder: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_status_feeder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        evt_valid = 1'b0;
  logic [2:0]  evt_code = 3'd0;
  logic        setx_valid = 1'b0;
  logic [26:0] setx_imm = 27'd0;
  logic        hold = 1'b0;
  logic [31:0] status_data;
  logic        status_w_en;
  logic        full;
  logic        empty;
  logic        dropped;
  logic [7:0]  drop_cnt;

  status_feeder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr         (clr),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .setx_valid  (setx_valid),
    .setx_imm    (setx_imm),
    .hold        (hold),
    .status_data (status_data),
    .status_w_en (status_w_en),
    .full        (full),
    .empty       (empty),
    .dropped     (dropped),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [31:0] q[$];
  logic        e_wen = 1'b0;
  logic [31:0] e_data = '0;
  logic        e_drop = 1'b0;
  int          e_cnt = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: pop the head if allowed, then queue what fits.
  task automatic model_edge();
    int  lost;
    bit  ok;
    lost = 0;
    if (clr) begin
      q.delete();
      e_wen  = 1'b0;
      e_data = '0;
      e_drop = 1'b0;
      e_cnt  = 0;
    end else begin
      ok = evt_valid && evt_code >= 1 && evt_code <= 5;
      e_wen = (q.size() > 0) && !hold;
      if (e_wen) e_data = q.pop_front();
      if (ok && setx_valid) lost++;
      if (ok || setx_valid) begin
        if (q.size() < DEPTH)
          q.push_back(ok ? {29'b0, evt_code}
                         : {5'b0, setx_imm});
        else
          lost++;
      end
      if (lost > 0) e_drop = 1'b1;
`ifdef STATUS_FEEDER_DROP_CNT_EN
      e_cnt = e_cnt + lost;
      if (e_cnt > 255) e_cnt = 255;
`else
      e_cnt = 0;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("w_en", {31'b0, status_w_en}, {31'b0, e_wen});
    check("data", status_data, e_data);
    check("full", {31'b0, full},
          {31'b0, q.size() == DEPTH});
    check("empty", {31'b0, empty},
          {31'b0, q.size() == 0});
    check("dropped", {31'b0, dropped}, {31'b0, e_drop});
    check("drop_cnt", {24'b0, drop_cnt}, e_cnt);
  endtask

  task automatic drive(input logic c, input logic ev,
                       input logic [2:0] code,
                       input logic sx, input logic [26:0] imm,
                       input logic h);
    clr        = c;
    evt_valid  = ev;
    evt_code   = code;
    setx_valid = sx;
    setx_imm   = imm;
    hold       = h;
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, h);
      tick();
    end
  endtask

  task automatic reset();
    drive(1, 1, 3'd2, 1, 27'h1234, 0);
    tick();
  endtask

  int hold_pct;

  initial begin
    reset();
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_data", status_data, 32'd0);

    // single exception, strobe two edges later
    drive(0, 1, 3'd3, 0, 0, 0);
    tick();
    check("one_nowen", {31'b0, status_w_en}, 32'd0);
    idle(1, 0);
    check("one_wen", {31'b0, status_w_en}, 32'd1);
    check("one_data", status_data, 32'h3);
    idle(2, 0);

    // setx
    drive(0, 0, 0, 1, 27'h7FFFFFF, 0);
    tick();
    idle(1, 0);
    check("setx_data", status_data, 32'h07FFFFFF);
    idle(2, 0);

    // overflow under hold, then ordered drain
    reset();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 3'(i), 0, 0, 1);
      tick();
    end
    check("ovf_full", {31'b0, full}, 32'd1);
    check("ovf_drop", {31'b0, dropped}, 32'd1);
    idle(6, 0);

    // collision
    reset();
    drive(0, 1, 3'd4, 1, 27'h55, 0);
    tick();
    idle(3, 0);
    check("col_data", status_data, 32'h4);

    // invalid code
    reset();
    drive(0, 1, 3'd7, 0, 0, 0);
    tick();
    idle(3, 0);
    check("inv_drop", {31'b0, dropped}, 32'd0);

    // mid-drain reset
    reset();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 3'(i), 0, 0, 1);
      tick();
    end
    idle(1, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    idle(4, 0);
    check("mdr_empty", {31'b0, empty}, 32'd1);

    // drop counter saturation
    reset();
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 3'd1, i[0], 27'(i), 1);
      tick();
    end
    idle(6, 0);

    // random traffic
    reset();
    hold_pct = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) hold_pct = $urandom_range(0, 95);
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 1),
            3'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 3,
            27'($urandom),
            $urandom_range(0, 99) < hold_pct);
      tick();
    end
    idle(8, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
